// File: rtl/avalon_timer_mch_if.sv
// Avalon-MM slave bus bundle for the multi-channel interval timer.
// Latency: n/a (wires only); readdata is registered inside the timer.
// Backpressure: none, the slave never inserts wait states.
interface avalon_timer_mch_if #(
  parameter int AW = 4
);
  logic [AW-1:0] address;
  logic          chipselect;
  logic          write_n;
  logic [31:0]   writedata;
  logic [31:0]   readdata;

  modport master (output address, output chipselect, output write_n,
                  output writedata, input readdata);
  modport slave  (input address, input chipselect, input write_n,
                  input writedata, output readdata);
endinterface

// File: rtl/avalon_timer_mch.sv
// Multi-channel Avalon-MM interval timer: per-channel prescaler, down-counter, snapshot, irq.
// Latency: writes land on the next edge; readdata is valid one cycle after address.
// Backpressure: none, no wait states. Optional PWM outputs: AVALON_TIMER_MCH_PWM_EN.
module avalon_timer_mch #(
  parameter int NUM_CH     = 2,
  parameter int CNT_W      = 32,
  parameter int PRE_W      = 8,
  parameter int RST_PERIOD = 9
) (
  input  logic               clk,
  input  logic               reset,
  avalon_timer_mch_if.slave  bus,
  output logic [NUM_CH-1:0]  irq
`ifdef AVALON_TIMER_MCH_PWM_EN
  ,
  output logic [NUM_CH-1:0]  pwm_out
`endif
);

  localparam logic [CNT_W-1:0] RST_CNT = CNT_W'(RST_PERIOD);

  logic [NUM_CH-1:0][CNT_W-1:0] cnt_q, cnt_d, per_q, per_d, snap_q, snap_d;
  logic [NUM_CH-1:0][PRE_W-1:0] pre_q, pre_d, pre_cnt_q, pre_cnt_d;
  logic [NUM_CH-1:0]            ito_q, ito_d, cont_q, cont_d;
  logic [NUM_CH-1:0]            run_q, run_d, to_q, to_d;
  logic [NUM_CH-1:0]            tick;
  logic [NUM_CH-1:0][7:0]       wr_hit;
  logic [31:0]                  rd_q, rd_d;
  logic [31:0]                  addr_ext;
  logic [28:0]                  ch_sel;
  logic [2:0]                   reg_sel;
  logic                         wr;
`ifdef AVALON_TIMER_MCH_PWM_EN
  logic [NUM_CH-1:0][CNT_W-1:0] cmp_q, cmp_d;
  logic [NUM_CH-1:0]            pwm_q, pwm_d;
`endif

  assign addr_ext = 32'(bus.address);
  assign ch_sel   = addr_ext[31:3];
  assign reg_sel  = addr_ext[2:0];
  assign wr       = bus.chipselect & ~bus.write_n;

  // Decode a write into one strobe per (channel, register); unmapped channels get none.
  always_comb begin
    wr_hit = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      for (int r = 0; r < 8; r++) begin
        wr_hit[i][r] = wr && (ch_sel == 29'(i)) && (reg_sel == 3'(r));
      end
    end
  end

  // Per-channel prescale tick: only meaningful while the channel runs.
  always_comb begin
    tick = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      tick[i] = run_q[i] && (pre_cnt_q[i] == pre_q[i]);
    end
  end

  // Next-state for every channel; later assignments carry higher priority.
  always_comb begin
    cnt_d     = cnt_q;
    per_d     = per_q;
    snap_d    = snap_q;
    pre_d     = pre_q;
    pre_cnt_d = pre_cnt_q;
    ito_d     = ito_q;
    cont_d    = cont_q;
    run_d     = run_q;
    to_d      = to_q;
`ifdef AVALON_TIMER_MCH_PWM_EN
    cmp_d     = cmp_q;
    pwm_d     = '0;
`endif
    for (int i = 0; i < NUM_CH; i++) begin
      if (!run_q[i] || tick[i]) pre_cnt_d[i] = '0;
      else                      pre_cnt_d[i] = pre_cnt_q[i] + 1'b1;

      // Clear first so that a timeout in the same cycle still sets TO.
      if (wr_hit[i][0]) to_d[i] = 1'b0;

      if (tick[i]) begin
        if (cnt_q[i] == '0) begin
          cnt_d[i] = per_q[i];
          to_d[i]  = 1'b1;
          if (!cont_q[i]) run_d[i] = 1'b0;
        end else begin
          cnt_d[i] = cnt_q[i] - 1'b1;
        end
      end

      if (wr_hit[i][1]) begin
        ito_d[i]  = bus.writedata[0];
        cont_d[i] = bus.writedata[1];
        if (bus.writedata[3]) begin
          run_d[i] = 1'b0;
        end else if (bus.writedata[2]) begin
          run_d[i]     = 1'b1;
          pre_cnt_d[i] = '0;
        end
      end

      // A new period forces a reload and parks the channel until the next START.
      if (wr_hit[i][2]) begin
        per_d[i]     = bus.writedata[CNT_W-1:0];
        cnt_d[i]     = bus.writedata[CNT_W-1:0];
        run_d[i]     = 1'b0;
        pre_cnt_d[i] = '0;
      end

      if (wr_hit[i][3]) begin
        pre_d[i]     = bus.writedata[PRE_W-1:0];
        pre_cnt_d[i] = '0;
      end

      // Snapshot takes the registered count, i.e. the value before this cycle's decrement.
      if (wr_hit[i][4]) snap_d[i] = cnt_q[i];

`ifdef AVALON_TIMER_MCH_PWM_EN
      if (wr_hit[i][6]) cmp_d[i] = bus.writedata[CNT_W-1:0];
      pwm_d[i] = run_q[i] && (cnt_q[i] < cmp_q[i]);
`endif
    end
  end

  // Read mux, registered into readdata; unmapped channels and reserved registers read 0.
  always_comb begin
    rd_d = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch_sel == 29'(i)) begin
        case (reg_sel)
          3'd0:    rd_d = {30'd0, run_q[i], to_q[i]};
          3'd1:    rd_d = {30'd0, cont_q[i], ito_q[i]};
          3'd2:    rd_d = 32'(per_q[i]);
          3'd3:    rd_d = 32'(pre_q[i]);
          3'd4:    rd_d = 32'(snap_q[i]);
          3'd5:    rd_d = 32'(cnt_q[i]);
`ifdef AVALON_TIMER_MCH_PWM_EN
          3'd6:    rd_d = 32'(cmp_q[i]);
`endif
          default: rd_d = '0;
        endcase
      end
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q     <= {NUM_CH{RST_CNT}};
      per_q     <= {NUM_CH{RST_CNT}};
      snap_q    <= '0;
      pre_q     <= '0;
      pre_cnt_q <= '0;
      ito_q     <= '0;
      cont_q    <= '0;
      run_q     <= '0;
      to_q      <= '0;
      rd_q      <= '0;
`ifdef AVALON_TIMER_MCH_PWM_EN
      cmp_q     <= '0;
      pwm_q     <= '0;
`endif
    end else begin
      cnt_q     <= cnt_d;
      per_q     <= per_d;
      snap_q    <= snap_d;
      pre_q     <= pre_d;
      pre_cnt_q <= pre_cnt_d;
      ito_q     <= ito_d;
      cont_q    <= cont_d;
      run_q     <= run_d;
      to_q      <= to_d;
      rd_q      <= rd_d;
`ifdef AVALON_TIMER_MCH_PWM_EN
      cmp_q     <= cmp_d;
      pwm_q     <= pwm_d;
`endif
    end
  end

  assign bus.readdata = rd_q;
  assign irq          = to_q & ito_q;
`ifdef AVALON_TIMER_MCH_PWM_EN
  assign pwm_out      = pwm_q;
`endif

endmodule

// File: tb/tb_avalon_timer_mch.sv
// Self-checking bench for avalon_timer_mch: directed scenarios plus randomized runs
// checked against an arithmetic model of timer count/timeout versus elapsed cycles.
// PWM checks are included when AVALON_TIMER_MCH_PWM_EN is defined.
module tb_avalon_timer_mch;
  localparam int NUM_CH = 3;
  localparam int AW     = $clog2(NUM_CH) + 3;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [NUM_CH-1:0] irq;
`ifdef AVALON_TIMER_MCH_PWM_EN
  logic [NUM_CH-1:0] pwm_out;
`endif

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int frozen [NUM_CH];

  avalon_timer_mch_if #(.AW(AW)) bus_if ();

  avalon_timer_mch #(.NUM_CH(NUM_CH), .CNT_W(32), .PRE_W(8), .RST_PERIOD(9)) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus_if),
    .irq     (irq)
`ifdef AVALON_TIMER_MCH_PWM_EN
    ,
    .pwm_out (pwm_out)
`endif
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic wr(input int ch, input int r, input logic [31:0] d);
    bus_if.address    = AW'((ch << 3) | r);
    bus_if.chipselect = 1'b1;
    bus_if.write_n    = 1'b0;
    bus_if.writedata  = d;
    step();
    bus_if.chipselect = 1'b0;
    bus_if.write_n    = 1'b1;
  endtask

  // Returned data reflects register state after edge number cyc-1.
  task automatic rd(input int ch, input int r, output logic [31:0] d);
    bus_if.address    = AW'((ch << 3) | r);
    bus_if.chipselect = 1'b1;
    bus_if.write_n    = 1'b1;
    step();
    d = bus_if.readdata;
    bus_if.chipselect = 1'b0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Timer state n cycles after START: ticks = n/(S+1); each tick steps P..0, reload on the next.
  function automatic void model(input int p, input int s, input int cont, input int n,
                                output int cnt, output int to, output int run);
    int t;
    t = n / (s + 1);
    if (t >= p + 1) begin
      to = 1;
      if (cont != 0) begin
        cnt = p - (t % (p + 1));
        run = 1;
      end else begin
        cnt = p;
        run = 0;
      end
    end else begin
      to  = 0;
      run = 1;
      cnt = p - t;
    end
  endfunction

  initial begin
    logic [31:0] d;
    int e0, e1, ch, oth, p, s, cont, w, mc, mt, mr, snap_exp;

    bus_if.address    = '0;
    bus_if.chipselect = 1'b0;
    bus_if.write_n    = 1'b1;
    bus_if.writedata  = '0;
    repeat (3) step();
    reset = 1'b0;
    step();

    // Reset state
    check("rst_irq", 32'(irq), 32'd0);
    rd(0, 2, d); check("rst_period", d, 32'd9);
    rd(0, 5, d); check("rst_count", d, 32'd9);
    rd(0, 0, d); check("rst_status", d, 32'd0);
    rd(0, 1, d); check("rst_control", d, 32'd0);
    rd(0, 4, d); check("rst_snap", d, 32'd0);
    rd(0, 7, d); check("reserved7", d, 32'd0);
`ifndef AVALON_TIMER_MCH_PWM_EN
    rd(0, 6, d); check("reserved6", d, 32'd0);
`endif
    wr(3, 2, 32'd55);
    rd(3, 2, d); check("unmapped_ch_read", d, 32'd0);
    rd(2, 2, d); check("unmapped_ch_write_isolated", d, 32'd9);

    // ch0 continuous, period 4, prescale 0: TO every 5 cycles
    wr(0, 2, 32'd4);
    wr(0, 3, 32'd0);
    wr(0, 1, 32'h7);
    e0 = cyc;
    for (int k = 1; k <= 5; k++) begin
      step();
      check("ch0_irq_first", 32'(irq[0]), (k == 5) ? 32'd1 : 32'd0);
    end
    wr(0, 0, 32'd0);
    check("ch0_status_clears_irq", 32'(irq[0]), 32'd0);
    while (cyc < e0 + 9) step();
    check("ch0_irq_before_2nd", 32'(irq[0]), 32'd0);
    step();
    check("ch0_irq_2nd", 32'(irq[0]), 32'd1);
    rd(0, 0, d); check("ch0_status_running", d, 32'd3);
    // STATUS write lands on the timeout edge e0+15: the set wins
    while (cyc < e0 + 14) step();
    wr(0, 0, 32'd0);
    rd(0, 0, d); check("status_wr_vs_timeout", d, 32'd3);

    // ch1 one-shot, period 2, prescale 3: irq after 12 cycles; ch0 parked with ITO off
    wr(0, 1, 32'h8);
    wr(1, 2, 32'd2);
    wr(1, 3, 32'd3);
    wr(1, 1, 32'h5);
    e1 = cyc;
    for (int k = 1; k <= 12; k++) begin
      step();
      check("ch1_irq", 32'(irq[1]), (k == 12) ? 32'd1 : 32'd0);
      check("ch0_irq_isolated", 32'(irq[0]), 32'd0);
    end
    rd(1, 0, d); check("ch1_oneshot_status", d, 32'd1);
    rd(1, 5, d); check("ch1_oneshot_count", d, 32'd2);

    // START with STOP: STOP wins
    wr(2, 1, 32'hC);
    rd(2, 0, d); check("start_stop_run", d, 32'd0);
    rd(2, 5, d); check("start_stop_count", d, 32'd9);

    // PERIOD write while running at count 3 forces reload and stops
    wr(0, 0, 32'd0);
    wr(0, 2, 32'd4);
    wr(0, 3, 32'd0);
    wr(0, 1, 32'h6);
    step();
    wr(0, 2, 32'd100);
    rd(0, 5, d); check("period_reload_count", d, 32'd100);
    rd(0, 0, d); check("period_reload_status", d, 32'd0);
    wr(0, 4, 32'd0);
    rd(0, 4, d); check("snap_after_reload", d, 32'd100);

    frozen[0] = 100;
    frozen[1] = 2;
    frozen[2] = 9;

    // Randomized runs against the arithmetic model
    for (int it = 0; it < 24; it++) begin
      ch   = $urandom_range(0, NUM_CH - 1);
      oth  = (ch + 1) % NUM_CH;
      p    = $urandom_range(1, 20);
      s    = $urandom_range(0, 3);
      cont = $urandom_range(0, 1);
      w    = $urandom_range(0, 40);
      wr(ch, 2, 32'(p));
      wr(ch, 3, 32'(s));
      wr(ch, 0, 32'd0);
      wr(ch, 1, 32'(5 | (cont << 1)));
      e0 = cyc;
      repeat (w) step();
      model(p, s, cont, cyc - e0, mc, mt, mr);
      check("rnd_irq", 32'(irq[ch]), 32'(mt));
      wr(ch, 4, 32'd0);
      model(p, s, cont, cyc - 1 - e0, mc, mt, mr);
      snap_exp = mc;
      rd(ch, 5, d);
      model(p, s, cont, cyc - 1 - e0, mc, mt, mr);
      check("rnd_count", d, 32'(mc));
      rd(ch, 0, d);
      model(p, s, cont, cyc - 1 - e0, mc, mt, mr);
      check("rnd_status", d, 32'((mr << 1) | mt));
      rd(ch, 4, d); check("rnd_snap", d, 32'(snap_exp));
      rd(oth, 5, d); check("rnd_other_frozen", d, 32'(frozen[oth]));
      wr(ch, 1, 32'h8);
      model(p, s, cont, cyc - e0, mc, mt, mr);
      frozen[ch] = mc;
    end

`ifdef AVALON_TIMER_MCH_PWM_EN
    begin
      int highs;
      highs = 0;
      wr(2, 6, 32'd3);
      rd(2, 6, d); check("pwm_compare_rd", d, 32'd3);
      check("pwm_stopped", 32'(pwm_out[2]), 32'd0);
      wr(2, 2, 32'd9);
      wr(2, 3, 32'd0);
      wr(2, 1, 32'h6);
      e0 = cyc;
      for (int k = 1; k <= 20; k++) begin
        step();
        model(9, 0, 1, k - 1, mc, mt, mr);
        check("pwm_level", 32'(pwm_out[2]), (mc < 3) ? 32'd1 : 32'd0);
        highs += int'(pwm_out[2]);
      end
      check("pwm_duty", 32'(highs), 32'd6);
    end
`endif

    // Reset mid-count: everything back to reset values, stays stopped after release
    wr(0, 2, 32'd4);
    wr(0, 1, 32'h7);
    repeat (2) step();
    reset = 1'b1;
    #2;
    check("midrst_irq", 32'(irq), 32'd0);
`ifdef AVALON_TIMER_MCH_PWM_EN
    check("midrst_pwm", 32'(pwm_out), 32'd0);
`endif
    step();
    reset = 1'b0;
    repeat (3) step();
    rd(0, 5, d); check("midrst_count", d, 32'd9);
    rd(0, 0, d); check("midrst_status", d, 32'd0);
    rd(0, 2, d); check("midrst_period", d, 32'd9);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
